// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode encodings, FSM states
// and the settle-counter width.
package alu_pkg;

  localparam logic [2:0] ALU_OP_NONE = 3'b000;
  localparam logic [2:0] ALU_OP_ADD  = 3'b001;
  localparam logic [2:0] ALU_OP_SUB  = 3'b010;
  localparam logic [2:0] ALU_OP_AND  = 3'b011;
  localparam logic [2:0] ALU_OP_OR   = 3'b100;
  localparam logic [2:0] ALU_OP_XOR  = 3'b101;
  localparam logic [2:0] ALU_OP_LSL  = 3'b110;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } alu_state_e;

  // 110 and 111 both decode as shift-left; only 000 is rejected.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op != ALU_OP_NONE;
  endfunction

endpackage

// File: rtl/alu_settle_cnt.sv
// Down-counter that times how long the ALU inputs are held before capture.
module alu_settle_cnt
  import alu_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequences one operation at a time onto an external ALU: issue, hold inputs
// for SETTLE_CYCLES, capture result and flags, then present a response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_din1,
  output logic [31:0] alu_din2,
  output logic [2:0]  alu_control,
  output logic        alu_run,
  input  logic [31:0] alu_dout,
  input  logic        alu_zf,
  input  logic        alu_vf,
  input  logic        alu_cf,
  input  logic        alu_nf,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [3:0]  resp_flags,
  output logic        resp_err,
  output alu_state_e  fsm_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both
  // high; valid never depends on ready, and the payload is stable while valid.

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  alu_state_e       state;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt;

  assign cnt_load  = (state == ST_ISSUE);
  assign cnt_dec   = (state == ST_SETTLE);
  assign fsm_state = state;

  alu_settle_cnt #(.W(CNT_W)) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      alu_run     <= 1'b1;
      alu_din1    <= '0;
      alu_din2    <= '0;
      alu_control <= ALU_OP_NONE;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_flags  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (op_is_legal(req_op)) begin
              // Operands go straight onto the ALU registers so they are
              // already stable during the ISSUE cycle.
              alu_din1    <= req_a;
              alu_din2    <= req_b;
              alu_control <= req_op;
              alu_run     <= 1'b0;
              state       <= ST_ISSUE;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              resp_flags <= '0;
              state      <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          resp_data  <= alu_dout;
          resp_flags <= {alu_nf, alu_zf, alu_cf, alu_vf};
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          alu_run    <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          alu_run   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: emulated 16-bit ALU, directed vectors, reset abort
// and randomized operations scored against an expected queue.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] alu_din1, alu_din2;
  logic [2:0]  alu_control;
  logic        alu_run;
  logic [31:0] alu_dout;
  logic        alu_zf, alu_vf, alu_cf, alu_nf;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [3:0]  resp_flags;
  logic        resp_err;
  alu_state_e  fsm_state;

  int tests = 0;
  int fails = 0;
  logic [36:0] exp_q[$];
  logic [31:0] last_a = '0, last_b = '0;
  logic [2:0]  last_op = '0;
  logic [31:0] obs_data;
  logic [3:0]  obs_flags;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_din1(alu_din1), .alu_din2(alu_din2), .alu_control(alu_control),
    .alu_run(alu_run), .alu_dout(alu_dout),
    .alu_zf(alu_zf), .alu_vf(alu_vf), .alu_cf(alu_cf), .alu_nf(alu_nf),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_flags(resp_flags), .resp_err(resp_err), .fsm_state(fsm_state)
  );

  // 16-bit ALU behaviour: returns {N,Z,C,V, sign-extended result}.
  function automatic logic [35:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [16:0] wide;
    logic [15:0] r;
    logic c, v;
    wide = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'b001: begin wide = {1'b0, a[15:0]} + {1'b0, b[15:0]}; r = wide[15:0]; c = wide[16];
                    v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'b010: begin r = a[15:0] - b[15:0]; c = (a[15:0] < b[15:0]);
                    v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'b011: r = a[15:0] & b[15:0];
      3'b100: r = a[15:0] | b[15:0];
      3'b101: r = a[15:0] ^ b[15:0];
      3'b110, 3'b111: r = a[15:0] << b[3:0];
      default: r = '0;
    endcase
    return {r[15], (r == 16'h0), c, v, {16{r[15]}}, r};
  endfunction

  logic [35:0] alu_now;
  always_comb alu_now = alu_fn(alu_control, alu_din1, alu_din2);
  assign alu_dout = alu_run ? 32'hDEADBEEF : alu_now[31:0];
  assign {alu_nf, alu_zf, alu_cf, alu_vf} = alu_run ? 4'b0101 : alu_now[35:32];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    int lat, run_low;
    logic [36:0] exp;
    @(negedge clk);
    check32("idle_ready", 32'(req_ready), 32'd1);
    check32("idle_run", 32'(alu_run), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; resp_ready = 1'b0;
    if (op == 3'b000) exp_q.push_back({1'b1, 36'h0});
    else exp_q.push_back({1'b0, alu_fn(op, a, b)});
    lat = 0; run_low = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid = 1'($urandom_range(0, 1));
      req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
      if (!resp_valid) begin
        if (req_ready) check32("busy_ready", 32'(req_ready), 32'd0);
        if (!alu_run) run_low++;
      end
    end while (!resp_valid && lat < 40);
    check32("latency", lat, (op != 3'b000) ? S + 3 : 1);
    check32("run_low_cycles", run_low, (op != 3'b000) ? S + 2 : 0);
    check32("resp_run_high", 32'(alu_run), 32'd1);
    check32("resp_busy_ready", 32'(req_ready), 32'd0);
    exp = exp_q.pop_front();
    check32("resp_data", resp_data, exp[31:0]);
    check32("resp_flags", 32'(resp_flags), 32'(exp[35:32]));
    check32("resp_err", 32'(resp_err), 32'(exp[36]));
    if (op != 3'b000) begin last_a = a; last_b = b; last_op = op; end
    check32("din1_hold", alu_din1, last_a);
    check32("din2_hold", alu_din2, last_b);
    check32("ctrl_hold", 32'(alu_control), 32'(last_op));
    obs_data = resp_data; obs_flags = resp_flags;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      check32("stall_valid", 32'(resp_valid), 32'd1);
      check32("stall_data", resp_data, exp[31:0]);
      check32("stall_flags", 32'(resp_flags), 32'(exp[35:32]));
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check32("post_hs_valid", 32'(resp_valid), 32'd0);
    check32("post_hs_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check32({tag, "_ready"}, 32'(req_ready), 32'd1);
    check32({tag, "_run"}, 32'(alu_run), 32'd1);
    check32({tag, "_din1"}, alu_din1, 32'h0);
    check32({tag, "_din2"}, alu_din2, 32'h0);
    check32({tag, "_ctrl"}, 32'(alu_control), 32'h0);
    check32({tag, "_valid"}, 32'(resp_valid), 32'd0);
    check32({tag, "_data"}, resp_data, 32'h0);
    check32({tag, "_flags"}, 32'(resp_flags), 32'h0);
    check32({tag, "_err"}, 32'(resp_err), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // add: 0x6075 + 0x5105
    run_op(3'b001, 32'h0000_6075, 32'h0000_5105, 0);
    check32("add_const", obs_data, 32'hFFFF_B17A);
    check32("add_n", 32'(obs_flags[3]), 32'd1);
    check32("add_z", 32'(obs_flags[2]), 32'd0);

    run_op(3'b010, 32'h0000_1F75, 32'h0000_108A, 1);
    check32("sub_const", obs_data, 32'h0000_0EEB);
    check32("sub_nz", 32'(obs_flags[3:2]), 32'd0);

    run_op(3'b011, 32'h0000_1F75, 32'h0000_108A, 0);
    check32("and_const", obs_data, 32'h0000_1000);
    run_op(3'b100, 32'h0000_1F75, 32'h0000_108A, 0);
    check32("or_const", obs_data, 32'h0000_1FFF);
    run_op(3'b101, 32'h0000_1F75, 32'h0000_108A, 0);
    check32("xor_const", obs_data, 32'h0000_0FFF);

    run_op(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    check32("illegal_data", obs_data, 32'h0);

    // long consumer stall
    run_op(3'b001, 32'h0000_7FFF, 32'h0000_0001, 10);
    check32("stall_const", obs_data, 32'hFFFF_8000);

    // reset asserted mid-SETTLE aborts the operation
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b001; req_a = 32'h0000_0011; req_b = 32'h0000_0022;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check32("in_settle", 32'(fsm_state), 32'(ST_SETTLE));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("abort");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check32("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    last_a = '0; last_b = '0; last_op = '0;
    run_op(3'b001, 32'h0000_6075, 32'h0000_5105, 0);
    check32("after_abort_add", obs_data, 32'hFFFF_B17A);

    for (int n = 0; n < 30; n++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));
    end
    check32("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
